// File: rtl/mux_stream_rr.sv
// N-channel registered stream multiplexer.
// Fixed-select or round-robin grant into one output register.
module mux_stream_rr #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [CW-1:0]     sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CW-1:0]     out_ch,
  input  logic              out_ready
);

  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] rr_g;
  logic [CW-1:0] idx;
  logic [CW-1:0] g;
  logic [W-1:0]  g_data;
  logic          rr_hit;
  logic          fx_hit;
  logic          hit;
  logic          load_en;
  logic          xfer;

  // Round-robin search: first valid channel at or after rr_ptr.
  always_comb begin
    rr_hit = 1'b0;
    rr_g   = '0;
    idx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = CW'((int'(rr_ptr) + i) % N_CH);
      if (!rr_hit && in_valid[idx]) begin
        rr_hit = 1'b1;
        rr_g   = idx;
      end
    end
  end

  // Pick the grant for the active mode and drive the ready lines.
  always_comb begin
    load_en  = !out_valid || out_ready;
    fx_hit   = int'(sel) < N_CH;
    hit      = mode ? rr_hit : fx_hit;
    g        = mode ? rr_g : sel;
    in_ready = '0;
    if (hit && load_en && !rst)
      in_ready = N_CH'(1) << g;
    xfer     = |(in_valid & in_ready);
  end

  // Data of the granted channel.
  always_comb begin
    g_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (g == CW'(k))
        g_data = in_data[k*W +: W];
    end
  end

  // Fairness pointer moves past the winner on each round-robin transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer && mode) begin
      rr_ptr <= (g == CW'(N_CH - 1)) ? '0 : g + 1'b1;
    end
  end

  // Output register: load on transfer, empty when free with no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= g_data;
        out_ch   <= g;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Scoreboard bench for mux_stream_rr.
// Reference grant model feeds a queue; monitor pops on output.
module tb_mux_stream_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [CW-1:0] sel;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ch;
  logic          out_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0]  d;
    logic [CW-1:0] ch;
  } item_t;

  item_t sb[$];
  bit    m_full;
  int    m_rr;

  mux_stream_rr #(.N_CH(N), .W(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant by scanning channels from the fairness pointer.
  always @(negedge clk) begin
    int g;
    int k;
    bit hit;
    bit ld;
    bit acc;
    logic [N-1:0] er;
    if (rst) begin
      m_full = 1'b0;
      m_rr   = 0;
      sb.delete();
    end else begin
      chk("out_valid", 32'(out_valid), 32'(m_full));
      ld  = !m_full || out_ready;
      hit = 1'b0;
      g   = 0;
      if (mode) begin
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (!hit && in_valid[k]) begin
            hit = 1'b1;
            g   = k;
          end
        end
      end else begin
        g   = int'(sel);
        hit = g < N;
      end
      er = '0;
      if (ld && hit) er[g] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(er));
      acc = ld && hit && in_valid[g];
      if (acc) begin
        sb.push_back('{in_data[g*W +: W], CW'(g)});
        if (mode) m_rr = (g + 1) % N;
      end
      if (ld) m_full = acc;
    end
  end

  // Monitor: compare the held word against the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty got=%0h/%0d want=none t=%0t",
                 out_data, out_ch, $time);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb[0].d));
        chk("out_ch", 32'(out_ch), 32'(sb[0].ch));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rnd_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fixed select channel 2.
    mode    = 1'b0;
    sel     = 2'd2;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step(1);
    for (int i = 0; i < 4; i++) begin
      chk("fix_data", 32'(out_data), 32'hA2);
      chk("fix_ch", 32'(out_ch), 32'd2);
      chk("fix_ready", 32'(in_ready), 32'b0100);
      step(1);
    end

    // Round-robin, all valid.
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rnd_data();
      step(1);
    end

    // Round-robin, sparse valid.
    in_valid = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      rnd_data();
      out_ready = 1'($urandom_range(0, 1));
      step(1);
    end

    // Backpressure hold then release.
    in_valid  = '1;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_data();
      step(1);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step(2);

    // No valid inputs: output drains.
    in_valid = '0;
    step(3);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 1'($urandom);
      sel       = CW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rnd_data();
      step(1);
    end

    // Reset mid-stream with a word held.
    mode      = 1'b1;
    in_valid  = '1;
    out_ready = 1'b0;
    step(2);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ch", 32'(out_ch), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step(1);
    chk("post_rst_ch", 32'(out_ch), 32'd0);
    for (int i = 0; i < 6; i++) begin
      rnd_data();
      step(1);
    end
    in_valid = '0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
